// File: rtl/pmod_cls_display_sched.sv
`default_nettype none
// ============================================================================
// pmod_cls_display_sched : command sequencer in front of the PMOD CLS SPI driver
// Rev 1.0
// ============================================================================
module pmod_cls_display_sched #(
   parameter int unsigned parm_fast_simulation = 0,
   parameter int unsigned FCLK_ce              = 2500000,
   parameter int unsigned parm_refresh_ms      = 1000,
   parameter int unsigned parm_accept_tmo      = 8
) (
   input  logic         i_ext_spi_clk_x,
   input  logic         i_srst,
   input  logic         i_spi_ce_4x,
   input  logic [127:0] i_line1,
   input  logic [127:0] i_line2,
   input  logic         i_force_refresh,
   input  logic         i_cls_command_ready,
   output logic         o_cmd_wr_clear_display,
   output logic         o_cmd_wr_text_line1,
   output logic         o_cmd_wr_text_line2,
   output logic [127:0] o_dat_ascii_line1,
   output logic [127:0] o_dat_ascii_line2,
   output logic         o_busy
);

   localparam int unsigned c_ms         = (parm_fast_simulation != 0) ? 2 : parm_refresh_ms;
   localparam int unsigned c_period     = (FCLK_ce / 1000) * c_ms;
   localparam logic        c_refresh_en = (c_period != 0);
   localparam logic [23:0] c_tc         = (c_period != 0) ? 24'(c_period - 1) : 24'd0;
   localparam int unsigned c_tmo_w      = $clog2(parm_accept_tmo + 1);
   localparam logic [c_tmo_w-1:0] c_tmo_last = c_tmo_w'(parm_accept_tmo - 1);

   localparam logic [1:0] c_sel_clr = 2'd0;
   localparam logic [1:0] c_sel_l1  = 2'd1;
   localparam logic [1:0] c_sel_l2  = 2'd2;

   typedef enum logic [1:0] {
      ST_BOOT      = 2'd0,
      ST_IDLE      = 2'd1,
      ST_ISSUE     = 2'd2,
      ST_WAIT_DONE = 2'd3
   } state_t;

   state_t               state_q, state_d;
   logic [1:0]           sel_q, sel_d;
   logic                 pend_clr_q, pend_clr_d;
   logic                 pend_l1_q, pend_l1_d;
   logic                 pend_l2_q, pend_l2_d;
   logic [23:0]          timer_q, timer_d;
   logic [c_tmo_w-1:0]   tmo_q, tmo_d;
   logic                 cmd_clr_q, cmd_clr_d;
   logic                 cmd_l1_q, cmd_l1_d;
   logic                 cmd_l2_q, cmd_l2_d;
   logic [127:0]         dat1_q, dat1_d;
   logic [127:0]         dat2_q, dat2_d;
   logic                 refresh_tick;

   always_comb begin
      timer_d      = timer_q;
      refresh_tick = 1'b0;
      if (c_refresh_en && i_spi_ce_4x) begin
         if (timer_q == c_tc) begin
            timer_d      = 24'd0;
            refresh_tick = 1'b1;
         end else begin
            timer_d = timer_q + 24'd1;
         end
      end
   end

   always_comb begin
      state_d    = state_q;
      sel_d      = sel_q;
      tmo_d      = tmo_q;
      pend_clr_d = pend_clr_q;
      pend_l1_d  = pend_l1_q;
      pend_l2_d  = pend_l2_q;
      cmd_clr_d  = cmd_clr_q;
      cmd_l1_d   = cmd_l1_q;
      cmd_l2_d   = cmd_l2_q;
      dat1_d     = dat1_q;
      dat2_d     = dat2_q;
      if (i_spi_ce_4x) begin
         case (state_q)
            ST_BOOT: begin
               if (i_cls_command_ready) state_d = ST_IDLE;
            end
            ST_IDLE: begin
               // Text is compared against the last snapshot sent, so edits made
               // during a transfer show up as dirty once we are back here.
               pend_l1_d = pend_l1_q | (i_line1 != dat1_q);
               pend_l2_d = pend_l2_q | (i_line2 != dat2_q);
               tmo_d     = '0;
               if (pend_clr_q) begin
                  pend_clr_d = 1'b0;
                  sel_d      = c_sel_clr;
                  cmd_clr_d  = 1'b1;
                  state_d    = ST_ISSUE;
               end else if (pend_l1_d) begin
                  pend_l1_d = 1'b0;
                  sel_d     = c_sel_l1;
                  dat1_d    = i_line1;
                  cmd_l1_d  = 1'b1;
                  state_d   = ST_ISSUE;
               end else if (pend_l2_d) begin
                  pend_l2_d = 1'b0;
                  sel_d     = c_sel_l2;
                  dat2_d    = i_line2;
                  cmd_l2_d  = 1'b1;
                  state_d   = ST_ISSUE;
               end
            end
            ST_ISSUE: begin
               if (!i_cls_command_ready) begin
                  cmd_clr_d = 1'b0;
                  cmd_l1_d  = 1'b0;
                  cmd_l2_d  = 1'b0;
                  state_d   = ST_WAIT_DONE;
               end else if (tmo_q == c_tmo_last) begin
                  // Driver never accepted: withdraw and queue the same command again.
                  cmd_clr_d = 1'b0;
                  cmd_l1_d  = 1'b0;
                  cmd_l2_d  = 1'b0;
                  case (sel_q)
                     c_sel_clr: pend_clr_d = 1'b1;
                     c_sel_l1:  pend_l1_d  = 1'b1;
                     default:   pend_l2_d  = 1'b1;
                  endcase
                  state_d = ST_IDLE;
               end else begin
                  tmo_d = tmo_q + c_tmo_w'(1);
               end
            end
            default: begin
               cmd_clr_d = 1'b0;
               cmd_l1_d  = 1'b0;
               cmd_l2_d  = 1'b0;
               if (i_cls_command_ready) state_d = ST_IDLE;
            end
         endcase
      end
      if (i_force_refresh || refresh_tick) begin
         pend_clr_d = 1'b1;
         pend_l1_d  = 1'b1;
         pend_l2_d  = 1'b1;
      end
   end

   always_ff @(posedge i_ext_spi_clk_x) begin
      if (i_srst) begin
         state_q    <= ST_BOOT;
         sel_q      <= c_sel_clr;
         tmo_q      <= '0;
         timer_q    <= 24'd0;
         pend_clr_q <= 1'b1;
         pend_l1_q  <= 1'b1;
         pend_l2_q  <= 1'b1;
         cmd_clr_q  <= 1'b0;
         cmd_l1_q   <= 1'b0;
         cmd_l2_q   <= 1'b0;
         dat1_q     <= '0;
         dat2_q     <= '0;
      end else begin
         state_q    <= state_d;
         sel_q      <= sel_d;
         tmo_q      <= tmo_d;
         timer_q    <= timer_d;
         pend_clr_q <= pend_clr_d;
         pend_l1_q  <= pend_l1_d;
         pend_l2_q  <= pend_l2_d;
         cmd_clr_q  <= cmd_clr_d;
         cmd_l1_q   <= cmd_l1_d;
         cmd_l2_q   <= cmd_l2_d;
         dat1_q     <= dat1_d;
         dat2_q     <= dat2_d;
      end
   end

   assign o_cmd_wr_clear_display = cmd_clr_q;
   assign o_cmd_wr_text_line1    = cmd_l1_q;
   assign o_cmd_wr_text_line2    = cmd_l2_q;
   assign o_dat_ascii_line1      = dat1_q;
   assign o_dat_ascii_line2      = dat2_q;
   assign o_busy = (state_q != ST_IDLE) | pend_clr_q | pend_l1_q | pend_l2_q;

endmodule
`default_nettype wire

// File: tb/tb_pmod_cls_display_sched.sv
`default_nettype none
// ============================================================================
// tb_pmod_cls_display_sched : scoreboard bench with a simple CLS driver model
// Rev 1.0
// ============================================================================
module tb_pmod_cls_display_sched;

   logic         clk = 1'b0;
   logic         srst;
   logic         ce;
   logic [127:0] line1, line2;
   logic         force_rf;
   logic         rdy;
   logic         cmd_clr, cmd_l1, cmd_l2;
   logic [127:0] dat1, dat2;
   logic         busy;

   typedef struct packed {
      logic [1:0]   kind;
      logic [127:0] data;
   } exp_t;

   exp_t sb_q[$];
   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;
   int   drv_stuck = 0;
   int   drv_low = 4;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   pmod_cls_display_sched #(
      .parm_fast_simulation (1),
      .FCLK_ce              (2500000),
      .parm_refresh_ms      (1000),
      .parm_accept_tmo      (8)
   ) dut (
      .i_ext_spi_clk_x        (clk),
      .i_srst                 (srst),
      .i_spi_ce_4x            (ce),
      .i_line1                (line1),
      .i_line2                (line2),
      .i_force_refresh        (force_rf),
      .i_cls_command_ready    (rdy),
      .o_cmd_wr_clear_display (cmd_clr),
      .o_cmd_wr_text_line1    (cmd_l1),
      .o_cmd_wr_text_line2    (cmd_l2),
      .o_dat_ascii_line1      (dat1),
      .o_dat_ascii_line2      (dat2),
      .o_busy                 (busy)
   );

   initial begin
      ce = 1'b0;
      forever begin
         @(negedge clk);
         ce = ~ce;
      end
   end

   // Driver model: accepts a command by dropping ready a few clocks after it appears.
   initial begin
      rdy = 1'b1;
      forever begin
         @(negedge clk);
         if (drv_stuck == 0 && (cmd_clr || cmd_l1 || cmd_l2)) begin
            repeat (3) @(negedge clk);
            rdy = 1'b0;
            repeat (drv_low) @(negedge clk);
            rdy = 1'b1;
         end
      end
   end

   initial begin : monitor
      logic       prev_any;
      logic [2:0] v;
      logic [1:0] kind;
      exp_t       e;
      prev_any = 1'b0;
      forever begin
         @(negedge clk);
         v = {cmd_l2, cmd_l1, cmd_clr};
         if (v != 3'b000) begin
            checks++;
            if (!$onehot(v)) begin
               errors++;
               $display("FAIL cmd_onehot: cmds=%b required a single bit", v);
            end
         end
         if (v != 3'b000 && !prev_any) begin
            kind = v[0] ? 2'd0 : (v[1] ? 2'd1 : 2'd2);
            checks++;
            if (sb_q.size() == 0) begin
               errors++;
               $display("FAIL unexpected_cmd: got kind=%0d with no command expected", kind);
            end else begin
               e = sb_q.pop_front();
               if (e.kind != kind) begin
                  errors++;
                  $display("FAIL cmd_order: got kind=%0d required kind=%0d", kind, e.kind);
               end else if (kind == 2'd1) begin
                  checks++;
                  if (dat1 !== e.data) begin
                     errors++;
                     $display("FAIL line1_data: got %h required %h", dat1, e.data);
                  end
               end else if (kind == 2'd2) begin
                  checks++;
                  if (dat2 !== e.data) begin
                     errors++;
                     $display("FAIL line2_data: got %h required %h", dat2, e.data);
                  end
               end
            end
         end
         prev_any = |v;
      end
   end

   task automatic expect_cmd(input logic [1:0] k, input logic [127:0] d);
      exp_t e;
      e.kind = k;
      e.data = d;
      sb_q.push_back(e);
   endtask

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %h required %h", name, act, req);
      end
   endtask

   task automatic wait_quiet(input string name, input int max);
      int quiet;
      int n;
      quiet = 0;
      n = 0;
      while (quiet < 12 && n < max) begin
         @(negedge clk);
         n++;
         if (!busy && rdy && !cmd_clr && !cmd_l1 && !cmd_l2) quiet++;
         else quiet = 0;
      end
      checks++;
      if (quiet < 12) begin
         errors++;
         $display("FAIL %s: still busy after %0d cycles, required idle", name, max);
      end
      chk({name, "_pending"}, 128'(sb_q.size()), 128'd0);
   endtask

   task automatic wait_for(input string name, input int what, input int max);
      int   n;
      logic hit;
      n = 0;
      hit = 1'b0;
      while (!hit && n < max) begin
         @(negedge clk);
         n++;
         case (what)
            0:       hit = cmd_clr;
            1:       hit = cmd_l1;
            2:       hit = cmd_l2;
            default: hit = !rdy;
         endcase
      end
      checks++;
      if (!hit) begin
         errors++;
         $display("FAIL %s: event %0d not seen within %0d cycles", name, what, max);
      end
   endtask

   initial begin : stim
      logic [127:0] s_l1a, s_l2a, s_hello, s_t3, s_mid, s_new, s_stuck, s_rst, s_strad;
      int w, c1, c2;
      s_l1a   = "LINE ONE TEXT   ";
      s_l2a   = "line two text   ";
      s_hello = "HELLO WORLD     ";
      s_t3    = "THIRD TEST LINE1";
      s_mid   = "MID TRANSFER L2a";
      s_new   = "NEWEST TEXT L2 b";
      s_stuck = "STUCK DRIVER L1 ";
      s_rst   = "RESET MID ISSUE ";
      s_strad = "REFRESH STRADDLE";

      srst = 1'b1;
      force_rf = 1'b0;
      line1 = s_l1a;
      line2 = s_l2a;
      repeat (4) @(negedge clk);
      chk("rst_cmds", 128'({cmd_l2, cmd_l1, cmd_clr}), 128'd0);
      chk("rst_dat1", dat1, 128'd0);
      chk("rst_dat2", dat2, 128'd0);
      chk("rst_busy", 128'(busy), 128'd1);

      // Full paint after reset
      expect_cmd(2'd0, '0);
      expect_cmd(2'd1, s_l1a);
      expect_cmd(2'd2, s_l2a);
      srst = 1'b0;
      wait_quiet("t1_paint", 400);
      chk("t1_busy", 128'(busy), 128'd0);

      // Single line change
      line1 = s_hello;
      expect_cmd(2'd1, s_hello);
      wait_quiet("t2_line1", 200);
      chk("t2_dat1", dat1, s_hello);

      // Force-refresh pulse landing on a clock without ce
      do @(posedge clk); while (!ce);
      #1 force_rf = 1'b1;
      expect_cmd(2'd0, '0);
      expect_cmd(2'd1, s_hello);
      expect_cmd(2'd2, s_l2a);
      @(posedge clk);
      #1 force_rf = 1'b0;
      wait_quiet("t2_force", 400);

      // Line 2 edits during transfers
      line1 = s_t3;
      expect_cmd(2'd1, s_t3);
      wait_for("t3_l1_cmd", 1, 50);
      wait_for("t3_l1_accept", 3, 50);
      line2 = s_mid;
      expect_cmd(2'd2, s_mid);
      wait_for("t3_l2_cmd", 2, 100);
      wait_for("t3_l2_accept", 3, 50);
      line2 = s_new;
      expect_cmd(2'd2, s_new);
      wait_quiet("t3_done", 300);
      chk("t3_dat2", dat2, s_new);

      // Stuck driver: command withdrawn after 8 ce cycles then reissued
      drv_stuck = 1;
      line1 = s_stuck;
      expect_cmd(2'd1, s_stuck);
      expect_cmd(2'd1, s_stuck);
      wait_for("t4_cmd", 1, 50);
      w = 0;
      while (cmd_l1 && w < 100) begin
         w++;
         @(negedge clk);
      end
      chk("t4_cmd_width", 128'(w), 128'd16);
      wait_for("t4_reissue", 1, 20);
      drv_stuck = 0;
      wait_quiet("t4_done", 300);

      // Reset while a command is being offered
      line1 = s_rst;
      expect_cmd(2'd1, s_rst);
      wait_for("t6_cmd", 1, 50);
      srst = 1'b1;
      @(negedge clk);
      chk("t6_cmds", 128'({cmd_l2, cmd_l1, cmd_clr}), 128'd0);
      chk("t6_dat1", dat1, 128'd0);
      chk("t6_dat2", dat2, 128'd0);
      chk("t6_busy", 128'(busy), 128'd1);
      repeat (12) @(negedge clk);
      expect_cmd(2'd0, '0);
      expect_cmd(2'd1, s_rst);
      expect_cmd(2'd2, s_new);
      srst = 1'b0;
      wait_quiet("t6_repaint", 400);

      // Periodic refresh: 5000 ce cycles = 10000 clocks apart
      expect_cmd(2'd0, '0);
      expect_cmd(2'd1, s_rst);
      expect_cmd(2'd2, s_new);
      wait_for("t5_refresh1", 0, 12000);
      c1 = cyc;
      wait_quiet("t5_refresh1_done", 400);
      expect_cmd(2'd0, '0);
      expect_cmd(2'd1, s_rst);
      expect_cmd(2'd2, s_new);
      wait_for("t5_refresh2", 0, 12000);
      c2 = cyc;
      chk("t5_period", 128'(c2 - c1), 128'd10000);
      wait_quiet("t5_refresh2_done", 400);

      // Refresh tick lands while a slow line2 transfer is in progress
      while (cyc < c2 + 9985) @(negedge clk);
      drv_low = 100;
      line2 = s_strad;
      expect_cmd(2'd2, s_strad);
      expect_cmd(2'd0, '0);
      expect_cmd(2'd1, s_rst);
      expect_cmd(2'd2, s_strad);
      wait_quiet("t5_straddle", 1200);
      drv_low = 4;
      chk("t5_dat2", dat2, s_strad);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
